// File: rtl/park_code_entry_pkg.sv
// Shared types and defaults for the car-park entry credential sender.
package park_code_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_PRESENT,
    ST_GRANTED,
    ST_DENIED,
    ST_LOCKOUT
  } state_t;

  typedef enum logic {
    DIG_NONE,
    DIG_ONE
  } dig_cnt_t;

  localparam int RESP_TIMEOUT_DEF  = 8;
  localparam int ENTRY_TIMEOUT_DEF = 1000;
  localparam int MAX_TRIES_DEF     = 3;
  localparam int LOCK_CYCLES_DEF   = 64;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/park_code_entry_timer.sv
// Loadable down-counter; o_expired stays high once a started count reaches zero until cleared.
module park_code_entry_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_load,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_run;

  // Start wins over clear so a restart in the same cycle is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= i_load;
      r_run <= 1'b1;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (r_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired = r_run && (r_cnt == '0);

endmodule

// File: rtl/park_code_entry.sv
// Keypad-to-gate credential sender: two-digit code entry, presentation, denial counting, lockout.
// state    | meaning
// IDLE     | no vehicle, outputs quiet
// ENTRY    | vehicle waiting, collecting digits
// PRESENT  | code on pswd, car_req high, waiting for gate_open
// GRANTED  | gate opened, code held until the vehicle leaves
// DENIED   | one-cycle denial pulse, fail count bumped
// LOCKOUT  | keypad and loop sensor ignored for LOCK_CYCLES
module park_code_entry
  import park_code_entry_pkg::*;
#(
  parameter int RESP_TIMEOUT  = RESP_TIMEOUT_DEF,
  parameter int ENTRY_TIMEOUT = ENTRY_TIMEOUT_DEF,
  parameter int MAX_TRIES     = MAX_TRIES_DEF,
  parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_car_present,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_key_clear,
  input  logic       i_gate_open,
  output logic       o_car_req,
  output logic [7:0] o_pswd,
  output logic       o_busy,
  output logic       o_denied,
  output logic       o_locked,
  output logic [1:0] o_fail_cnt
);

  localparam int RESP_W  = cnt_w(RESP_TIMEOUT);
  localparam int ENTRY_W = cnt_w(ENTRY_TIMEOUT);
  localparam int LOCK_W  = cnt_w(LOCK_CYCLES);
  localparam logic [RESP_W-1:0]  RESP_LOAD  = RESP_W'(RESP_TIMEOUT - 1);
  localparam logic [ENTRY_W-1:0] ENTRY_LOAD = ENTRY_W'(ENTRY_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]         MAX_T      = 2'(MAX_TRIES);

  state_t     r_state, w_state_nxt;
  dig_cnt_t   r_dig_cnt, w_dig_cnt_nxt;
  logic [3:0] r_hi, w_hi_nxt;
  logic [7:0] w_pswd_nxt;
  logic [1:0] w_fail_nxt;
  logic       w_ent_start, w_ent_clear, w_ent_exp;
  logic       w_resp_start, w_resp_clear, w_resp_exp;
  logic       w_lock_start, w_lock_clear, w_lock_exp;

  always_comb begin
    w_state_nxt   = r_state;
    w_dig_cnt_nxt = r_dig_cnt;
    w_hi_nxt      = r_hi;
    w_pswd_nxt    = o_pswd;
    w_fail_nxt    = o_fail_cnt;
    w_ent_start   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (i_car_present) w_state_nxt = ST_ENTRY;
      ST_ENTRY: begin
        if (!i_car_present) begin
          w_state_nxt   = ST_IDLE;
          w_dig_cnt_nxt = DIG_NONE;
        end else if (i_key_clear) begin
          w_dig_cnt_nxt = DIG_NONE;
        end else if (i_key_valid) begin
          if (r_dig_cnt == DIG_NONE) begin
            w_hi_nxt      = i_key_digit;
            w_dig_cnt_nxt = DIG_ONE;
            w_ent_start   = 1'b1;
          end else begin
            w_pswd_nxt    = {r_hi, i_key_digit};
            w_dig_cnt_nxt = DIG_NONE;
            w_state_nxt   = ST_PRESENT;
          end
        end else if ((r_dig_cnt == DIG_ONE) && w_ent_exp) begin
          w_dig_cnt_nxt = DIG_NONE;
        end
      end
      // Vehicle leaving outranks a grant, and a grant outranks a same-cycle timeout.
      ST_PRESENT: begin
        if (!i_car_present) begin
          w_state_nxt = ST_IDLE;
        end else if (i_gate_open) begin
          w_state_nxt = ST_GRANTED;
          w_fail_nxt  = 2'd0;
        end else if (w_resp_exp) begin
          w_state_nxt = ST_DENIED;
          w_fail_nxt  = (o_fail_cnt == MAX_T) ? o_fail_cnt : o_fail_cnt + 2'd1;
        end
      end
      ST_GRANTED: if (!i_car_present) w_state_nxt = ST_IDLE;
      ST_DENIED: begin
        if (o_fail_cnt == MAX_T)  w_state_nxt = ST_LOCKOUT;
        else if (i_car_present)   w_state_nxt = ST_ENTRY;
        else                      w_state_nxt = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (w_lock_exp) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = 2'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if ((w_state_nxt != ST_PRESENT) && (w_state_nxt != ST_GRANTED)) w_pswd_nxt = 8'h00;
  end

  assign w_ent_clear  = !((r_state == ST_ENTRY) && (r_dig_cnt == DIG_ONE));
  assign w_resp_start = (r_state == ST_ENTRY) && (w_state_nxt == ST_PRESENT);
  assign w_resp_clear = (r_state != ST_PRESENT);
  assign w_lock_start = (r_state == ST_DENIED) && (w_state_nxt == ST_LOCKOUT);
  assign w_lock_clear = (r_state != ST_LOCKOUT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_dig_cnt  <= DIG_NONE;
      r_hi       <= 4'h0;
      o_pswd     <= 8'h00;
      o_fail_cnt <= 2'd0;
      o_car_req  <= 1'b0;
      o_busy     <= 1'b0;
      o_denied   <= 1'b0;
      o_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dig_cnt  <= w_dig_cnt_nxt;
      r_hi       <= w_hi_nxt;
      o_pswd     <= w_pswd_nxt;
      o_fail_cnt <= w_fail_nxt;
      o_car_req  <= (w_state_nxt == ST_PRESENT) || (w_state_nxt == ST_GRANTED);
      o_busy     <= (w_state_nxt != ST_IDLE);
      o_denied   <= (w_state_nxt == ST_DENIED);
      o_locked   <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  park_code_entry_timer #(.WIDTH(ENTRY_W)) u_entry_timer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_ent_start), .i_clear(w_ent_clear),
    .i_load(ENTRY_LOAD), .o_expired(w_ent_exp)
  );

  park_code_entry_timer #(.WIDTH(RESP_W)) u_resp_timer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_resp_start), .i_clear(w_resp_clear),
    .i_load(RESP_LOAD), .o_expired(w_resp_exp)
  );

  park_code_entry_timer #(.WIDTH(LOCK_W)) u_lock_timer (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_lock_start), .i_clear(w_lock_clear),
    .i_load(LOCK_LOAD), .o_expired(w_lock_exp)
  );

endmodule

// File: tb/tb_park_code_entry.sv
// Self-checking bench for park_code_entry: vector table, directed corner sequences, random run vs model.
module tb_park_code_entry;

  localparam int RESP  = 8;
  localparam int ENTTO = 1000;
  localparam int MAXT  = 3;
  localparam int LOCKC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cp = 1'b0, kv = 1'b0, kc = 1'b0, go = 1'b0;
  logic [3:0] kd = 4'h0;
  logic       car_req, busy, denied, locked;
  logic [7:0] pswd;
  logic [1:0] fail_cnt;

  int n_chk = 0;
  int n_fail = 0;

  park_code_entry dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_car_present(cp), .i_key_valid(kv),
    .i_key_digit(kd), .i_key_clear(kc), .i_gate_open(go),
    .o_car_req(car_req), .o_pswd(pswd), .o_busy(busy), .o_denied(denied),
    .o_locked(locked), .o_fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the driver sees, tracked as plain flags, ages and a digit queue.
  bit         m_entry, m_present, m_granted, m_denied;
  int         m_q[$];
  int         m_idle, m_age, m_lock_left, m_fails;
  logic [7:0] m_code;

  task automatic model_reset();
    m_entry = 0; m_present = 0; m_granted = 0; m_denied = 0;
    m_q.delete();
    m_idle = 0; m_age = 0; m_lock_left = 0; m_fails = 0; m_code = 8'h00;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_denied) begin
      m_denied = 0;
      if (m_fails == MAXT) m_lock_left = LOCKC;
      else if (cp) m_entry = 1;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_granted) begin
      if (!cp) m_granted = 0;
    end else if (m_present) begin
      if (!cp) m_present = 0;
      else if (go) begin m_present = 0; m_granted = 1; m_fails = 0; end
      else begin
        m_age++;
        if (m_age == RESP) begin
          m_present = 0; m_denied = 1;
          if (m_fails < MAXT) m_fails++;
        end
      end
    end else if (m_entry) begin
      if (!cp) begin m_entry = 0; m_q.delete(); end
      else if (kc) m_q.delete();
      else if (kv) begin
        m_q.push_back(int'(kd));
        m_idle = 0;
        if (m_q.size() == 2) begin
          m_code = 8'(m_q[0] * 16 + m_q[1]);
          m_q.delete();
          m_entry = 0; m_present = 1; m_age = 0;
        end
      end else if (m_q.size() == 1) begin
        m_idle++;
        if (m_idle == ENTTO) m_q.delete();
      end
    end else if (cp) begin
      m_entry = 1;
    end
  endtask

  function automatic logic [14:0] model_out();
    logic cr;
    cr = m_present || m_granted;
    return {cr, cr ? m_code : 8'h00,
            m_entry || m_present || m_granted || m_denied || (m_lock_left > 0),
            m_denied, m_lock_left > 0, 2'(m_fails)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int c, input int v, input int d, input int clr, input int g);
    cp = c[0]; kv = v[0]; kd = d[3:0]; kc = clr[0]; go = g[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", {17'd0, car_req, pswd, busy, denied, locked, fail_cnt}, {17'd0, model_out()});
  endtask

  task automatic deny_once();
    int n;
    drive(1, 1, 4'hF, 0, 0); step();
    drive(1, 1, 4'hA, 0, 0); step();
    drive(1, 0, 0, 0, 0);
    n = 0;
    while (!denied && n < 20) begin step(); n++; end
    check("deny_latency", n, RESP);
    step();
  endtask

  typedef struct {
    logic       cp, kv;
    logic [3:0] kd;
    logic       kc, go;
    logic       cr;
    logic [7:0] pw;
    logic       bz, dn, lk;
    logic [1:0] fc;
  } vec_t;

  function automatic vec_t mk(input int c, input int v, input int d, input int clr, input int g,
                              input int cr, input int pw, input int bz, input int dn,
                              input int lk, input int fc);
    vec_t t;
    t.cp = c[0]; t.kv = v[0]; t.kd = d[3:0]; t.kc = clr[0]; t.go = g[0];
    t.cr = cr[0]; t.pw = pw[7:0]; t.bz = bz[0]; t.dn = dn[0]; t.lk = lk[0]; t.fc = fc[1:0];
    return t;
  endfunction

  vec_t tbl[13];

  initial begin
    int n;
    tbl[0]  = mk(0, 0, 0,   0, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0,   0, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 'hC, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 'h2, 0, 0,  1, 8'hC2, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0,   0, 1,  1, 8'hC2, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0,   0, 0,  1, 8'hC2, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,   0, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 'h5, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[8]  = mk(1, 1, 'h3, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 'h4, 1, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[10] = mk(1, 1, 'h7, 0, 0,  0, 8'h00, 1, 0, 0, 0);
    tbl[11] = mk(1, 1, 'h1, 0, 0,  1, 8'h71, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,   0, 0,  0, 8'h00, 0, 0, 0, 0);

    model_reset();
    #12;
    check("reset_outputs", {car_req, pswd, busy, denied, locked, fail_cnt}, 15'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].cp, tbl[i].kv, tbl[i].kd, tbl[i].kc, tbl[i].go);
      step();
      check($sformatf("vec%0d", i), {car_req, pswd, busy, denied, locked, fail_cnt},
            {tbl[i].cr, tbl[i].pw, tbl[i].bz, tbl[i].dn, tbl[i].lk, tbl[i].fc});
    end

    // Single denial: F,A with no gate response.
    drive(1, 0, 0, 0, 0); step();
    deny_once();
    check("deny_fail_cnt", fail_cnt, 1);
    check("deny_back_to_entry", {car_req, busy}, 2'b01);

    // Two more denials reach lockout; keys and sensor ignored while locked.
    deny_once();
    check("fail_cnt_2", fail_cnt, 2);
    deny_once();
    check("locked_entry", locked, 1);
    n = 0;
    while (locked && n < 200) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 15), 0, 0);
      step();
      n++;
    end
    check("lock_cycles", n, LOCKC);
    check("lock_exit", {busy, fail_cnt}, 3'b000);

    // Vehicle leaves while presenting: fail count survives.
    drive(1, 0, 0, 0, 0); step();
    deny_once();
    drive(1, 1, 4'h3, 0, 0); step();
    drive(1, 1, 4'h4, 0, 0); step();
    check("present_34", {car_req, pswd}, {1'b1, 8'h34});
    drive(0, 0, 0, 0, 0); step();
    check("car_leaves", {car_req, busy, fail_cnt}, {2'b00, 2'd1});

    // Entry timeout: 1000 idle cycles discard the first digit.
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 4'hC, 0, 0); step();
    drive(1, 0, 0, 0, 0); repeat (ENTTO) step();
    drive(1, 1, 4'hC, 0, 0); step();
    check("timeout_discard", car_req, 0);
    drive(1, 1, 4'h2, 0, 0); step();
    check("timeout_then_C2", {car_req, pswd}, {1'b1, 8'hC2});
    drive(0, 0, 0, 0, 0); step();

    // 999 idle cycles keep the first digit.
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 4'hC, 0, 0); step();
    drive(1, 0, 0, 0, 0); repeat (ENTTO - 1) step();
    drive(1, 1, 4'h2, 0, 0); step();
    check("no_timeout_C2", {car_req, pswd}, {1'b1, 8'hC2});
    drive(0, 0, 0, 0, 0); step();

    // Asynchronous reset in the middle of PRESENT.
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 4'h1, 0, 0); step();
    drive(1, 1, 4'h9, 0, 0); step();
    check("pre_reset_present", {car_req, pswd}, {1'b1, 8'h19});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {car_req, pswd, busy, fail_cnt}, 12'd0);
    model_reset();
    drive(0, 0, 0, 0, 0);
    step();
    #2 rst_n = 1'b1;
    step();
    check("idle_after_reset", busy, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 20) != 0, ($urandom % 3) == 0, $urandom_range(0, 15),
            ($urandom % 25) == 0, ($urandom % 8) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

endmodule
